// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the 8-bit core's pipeline stages.
//   - Default data, register-address and memory-address widths.
//   - Default memory-wait abort limit.
//   - wb_state_t: states of the memory-access/writeback stage.
//   - op_kind_t / decode_op: classification of a retired operation.
package cpu_pkg;

  localparam int CPU_DW      = 8;   // register file / memory data width
  localparam int CPU_RAW     = 3;   // register address width (8 registers)
  localparam int CPU_MAW     = 8;   // data memory address width
  localparam int CPU_TIMEOUT = 15;  // memory wait cycles before abort

  typedef enum logic {
    IDLE = 1'b0,
    MEM  = 1'b1
  } wb_state_t;

  typedef enum logic [1:0] {
    OP_ALU   = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_kind_t;

  // A load takes priority when execute flags both a load and a store.
  function automatic op_kind_t decode_op(input logic is_load, input logic is_store);
    op_kind_t kind;
    if (is_load) begin
      kind = OP_LOAD;
    end else if (is_store) begin
      kind = OP_STORE;
    end else begin
      kind = OP_ALU;
    end
    return kind;
  endfunction

endpackage

// File: rtl/wb_timeout.sv
// wb_timeout: wait-cycle counter for an outstanding memory request.
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   i_clr     in   force count to zero (takes precedence over i_en)
//   i_en      in   count one more wait cycle
//   o_expired out  count has reached TIMEOUT-1 (the last allowed wait cycle)
// The count saturates at TIMEOUT-1 so it can never wrap if the owner
// fails to clear it.
module wb_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;
  logic          w_at_limit;

  assign w_at_limit = (r_count == LIMIT);
  assign o_expired  = w_at_limit;

  // Wait counter: cleared while no request is pending, saturating at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {CW{1'b0}};
    end else if (i_clr) begin
      r_count <= {CW{1'b0}};
    end else if (i_en && !w_at_limit) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/wb_unit.sv
// wb_unit: memory-access / writeback stage of the 8-bit core.
// Accepts one retired operation per ex_valid/ex_ready handshake. ALU results
// are written to the register file on the following cycle; loads and stores
// run a held req/ack transaction on the data memory port. The unit is the
// only driver of the register file write port, so at most one write happens
// per cycle.
//   clk, reset                         clock, synchronous active-high reset
//   ex_valid/ex_ready                  handshake with execute
//   ex_is_load, ex_is_store            operation kind (load wins if both)
//   ex_wr_en, ex_wr_addr, ex_result    ALU write, destination, result/address
//   ex_store_data                      data for stores
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until ack/abort
//   mem_ack, mem_rdata                 memory completion and load data
//   rf_wr_en/rf_wr_addr/rf_dat_in      register file write port
//   ld_busy, ld_busy_addr              in-flight load destination for decode
//   err                                sticky memory timeout flag
// Every output except ex_ready is a register; ex_ready depends only on the
// state register and reset.
module wb_unit
  import cpu_pkg::*;
#(
  parameter int DW      = CPU_DW,
  parameter int RAW     = CPU_RAW,
  parameter int MAW     = CPU_MAW,
  parameter int TIMEOUT = CPU_TIMEOUT
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ex_valid,
  output logic           ex_ready,
  input  logic           ex_is_load,
  input  logic           ex_is_store,
  input  logic           ex_wr_en,
  input  logic [RAW-1:0] ex_wr_addr,
  input  logic [DW-1:0]  ex_result,
  input  logic [DW-1:0]  ex_store_data,
  output logic           mem_req,
  output logic           mem_we,
  output logic [MAW-1:0] mem_addr,
  output logic [DW-1:0]  mem_wdata,
  input  logic           mem_ack,
  input  logic [DW-1:0]  mem_rdata,
  output logic           rf_wr_en,
  output logic [RAW-1:0] rf_wr_addr,
  output logic [DW-1:0]  rf_dat_in,
  output logic           ld_busy,
  output logic [RAW-1:0] ld_busy_addr,
  output logic           err
);

  wb_state_t r_state;
  op_kind_t  w_kind;
  logic      w_accept;
  logic      w_in_mem;
  logic      w_expired;
  logic      w_exit;

  assign ex_ready = (r_state == IDLE) && !reset;
  assign w_accept = ex_valid && ex_ready;
  assign w_kind   = decode_op(ex_is_load, ex_is_store);
  assign w_in_mem = (r_state == MEM);
  // Leaving MEM this cycle, either by ack or by abort.
  assign w_exit   = w_in_mem && (mem_ack || w_expired);

  // Counter is zero on the first MEM cycle and counts completed wait cycles.
  wb_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (!w_in_mem || w_exit),
    .i_en      (w_in_mem),
    .o_expired (w_expired)
  );

  // Stage FSM with all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= {MAW{1'b0}};
      mem_wdata    <= {DW{1'b0}};
      rf_wr_en     <= 1'b0;
      rf_wr_addr   <= {RAW{1'b0}};
      rf_dat_in    <= {DW{1'b0}};
      ld_busy      <= 1'b0;
      ld_busy_addr <= {RAW{1'b0}};
      err          <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse; address/data hold otherwise.
      rf_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (w_kind)
              OP_LOAD, OP_STORE: begin
                r_state   <= MEM;
                mem_req   <= 1'b1;
                mem_we    <= (w_kind == OP_STORE);
                mem_addr  <= MAW'(ex_result);
                mem_wdata <= ex_store_data;
                ld_busy   <= (w_kind == OP_LOAD);
                if (w_kind == OP_LOAD) begin
                  ld_busy_addr <= ex_wr_addr;
                end else begin
                  ld_busy_addr <= ld_busy_addr;
                end
              end
              OP_ALU: begin
                rf_wr_en <= ex_wr_en;
                if (ex_wr_en) begin
                  rf_wr_addr <= ex_wr_addr;
                  rf_dat_in  <= ex_result;
                end else begin
                  rf_wr_addr <= rf_wr_addr;
                  rf_dat_in  <= rf_dat_in;
                end
              end
              default: begin
                r_state <= IDLE;
              end
            endcase
          end else begin
            // mem_ack arriving while idle is deliberately ignored.
            r_state <= IDLE;
          end
        end
        MEM: begin
          if (mem_ack) begin
            // Ack beats a timeout expiring in the same cycle.
            r_state <= IDLE;
            mem_req <= 1'b0;
            ld_busy <= 1'b0;
            if (!mem_we) begin
              rf_wr_en   <= 1'b1;
              rf_wr_addr <= ld_busy_addr;
              rf_dat_in  <= mem_rdata;
            end else begin
              rf_wr_en <= 1'b0;
            end
          end else if (w_expired) begin
            r_state <= IDLE;
            mem_req <= 1'b0;
            ld_busy <= 1'b0;
            err     <= 1'b1;
          end else begin
            r_state <= MEM;
          end
        end
        default: begin
          r_state <= IDLE;
          mem_req <= 1'b0;
          ld_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: a transaction-level model predicts every
// output each cycle, and directed steps pin hand-computed values.
module tb_wb_unit;

  localparam int TO = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       ex_valid, ex_ready, ex_is_load, ex_is_store, ex_wr_en;
  logic [2:0] ex_wr_addr;
  logic [7:0] ex_result, ex_store_data;
  logic       mem_req, mem_we, mem_ack;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic       rf_wr_en;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_dat_in;
  logic       ld_busy;
  logic [2:0] ld_busy_addr;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  wb_unit dut (
    .clk           (clk),
    .reset         (reset),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_is_load    (ex_is_load),
    .ex_is_store   (ex_is_store),
    .ex_wr_en      (ex_wr_en),
    .ex_wr_addr    (ex_wr_addr),
    .ex_result     (ex_result),
    .ex_store_data (ex_store_data),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_dat_in     (rf_dat_in),
    .ld_busy       (ld_busy),
    .ld_busy_addr  (ld_busy_addr),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic       m_live = 1'b0;
  logic       m_busy, m_ld, m_err;
  logic [7:0] m_addr, m_wdata;
  logic [2:0] m_dest;
  int         m_wait;
  logic       e_rf_en;
  logic [2:0] e_rf_addr;
  logic [7:0] e_rf_dat;

  always @(posedge clk) begin
    if (reset) begin
      m_live    <= 1'b1;
      m_busy    <= 1'b0;
      m_ld      <= 1'b0;
      m_err     <= 1'b0;
      m_addr    <= 8'h00;
      m_wdata   <= 8'h00;
      m_dest    <= 3'd0;
      m_wait    <= 0;
      e_rf_en   <= 1'b0;
      e_rf_addr <= 3'd0;
      e_rf_dat  <= 8'h00;
    end else begin
      e_rf_en <= 1'b0;
      if (!m_busy) begin
        if (ex_valid) begin
          if (ex_is_load || ex_is_store) begin
            m_busy  <= 1'b1;
            m_ld    <= ex_is_load;
            m_addr  <= ex_result;
            m_wdata <= ex_store_data;
            m_dest  <= ex_wr_addr;
            m_wait  <= 0;
          end else if (ex_wr_en) begin
            e_rf_en   <= 1'b1;
            e_rf_addr <= ex_wr_addr;
            e_rf_dat  <= ex_result;
          end
        end
      end else begin
        // m_wait = number of request cycles already spent
        m_wait <= m_wait + 1;
        if (mem_ack) begin
          m_busy <= 1'b0;
          if (m_ld) begin
            e_rf_en   <= 1'b1;
            e_rf_addr <= m_dest;
            e_rf_dat  <= mem_rdata;
          end
        end else if (m_wait + 1 == TO) begin
          m_busy <= 1'b0;
          m_err  <= 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("ex_ready", {31'd0, ex_ready}, {31'd0, (!m_busy && !reset)});
      chk("mem_req", {31'd0, mem_req}, {31'd0, m_busy});
      if (m_busy) begin
        chk("mem_we", {31'd0, mem_we}, {31'd0, !m_ld});
        chk("mem_addr", {24'd0, mem_addr}, {24'd0, m_addr});
        if (!m_ld) chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, m_wdata});
      end
      chk("ld_busy", {31'd0, ld_busy}, {31'd0, (m_busy && m_ld)});
      if (m_busy && m_ld) chk("ld_busy_addr", {29'd0, ld_busy_addr}, {29'd0, m_dest});
      chk("rf_wr_en", {31'd0, rf_wr_en}, {31'd0, e_rf_en});
      chk("rf_wr_addr", {29'd0, rf_wr_addr}, {29'd0, e_rf_addr});
      chk("rf_dat_in", {24'd0, rf_dat_in}, {24'd0, e_rf_dat});
      chk("err", {31'd0, err}, {31'd0, m_err});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic ld, input logic st, input logic we,
                        input logic [2:0] a, input logic [7:0] r, input logic [7:0] sd);
    ex_valid      = v;
    ex_is_load    = ld;
    ex_is_store   = st;
    ex_wr_en      = we;
    ex_wr_addr    = a;
    ex_result     = r;
    ex_store_data = sd;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    step();
    // reset values
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    chk("rst_rf_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rst_rf_wr_addr", {29'd0, rf_wr_addr}, 32'd0);
    chk("rst_rf_dat_in", {24'd0, rf_dat_in}, 32'd0);
    chk("rst_ld_busy", {31'd0, ld_busy}, 32'd0);
    chk("rst_ld_busy_addr", {29'd0, ld_busy_addr}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, ex_ready}, 32'd1);

    // Back-to-back ALU writes r1=0x12, r2=0x34, then a non-writing op.
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 8'h12, 8'h00);
    step();
    chk("alu1_en", {31'd0, rf_wr_en}, 32'd1);
    chk("alu1_addr", {29'd0, rf_wr_addr}, 32'd1);
    chk("alu1_dat", {24'd0, rf_dat_in}, 32'h12);
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 8'h34, 8'h00);
    step();
    chk("alu2_en", {31'd0, rf_wr_en}, 32'd1);
    chk("alu2_addr", {29'd0, rf_wr_addr}, 32'd2);
    chk("alu2_dat", {24'd0, rf_dat_in}, 32'h34);
    set_op(1'b1, 1'b0, 1'b0, 1'b0, 3'd3, 8'h99, 8'h00);
    step();
    chk("alu_nowr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("alu_nowr_hold", {24'd0, rf_dat_in}, 32'h34);

    // Load 0x40 -> r5, ack on the third request cycle with 0xA7.
    set_op(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 8'h40, 8'h00);
    step();
    chk("ld_req1", {31'd0, mem_req}, 32'd1);
    chk("ld_we", {31'd0, mem_we}, 32'd0);
    chk("ld_addr", {24'd0, mem_addr}, 32'h40);
    chk("ld_busy_addr5", {29'd0, ld_busy_addr}, 32'd5);
    chk("ld_ready_low", {31'd0, ex_ready}, 32'd0);
    // ALU op r7=0xEE waits on execute while the load is in flight
    set_op(1'b1, 1'b0, 1'b0, 1'b1, 3'd7, 8'hEE, 8'h00);
    step();
    chk("ld_req2", {31'd0, mem_req}, 32'd1);
    step();
    chk("ld_req3", {31'd0, mem_req}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 8'hA7;
    step();
    mem_ack = 1'b0;
    chk("ld_wr_en", {31'd0, rf_wr_en}, 32'd1);
    chk("ld_wr_addr", {29'd0, rf_wr_addr}, 32'd5);
    chk("ld_wr_dat", {24'd0, rf_dat_in}, 32'hA7);
    chk("ld_req_done", {31'd0, mem_req}, 32'd0);
    chk("ld_busy_done", {31'd0, ld_busy}, 32'd0);
    step();
    chk("post_ld_alu_en", {31'd0, rf_wr_en}, 32'd1);
    chk("post_ld_alu_addr", {29'd0, rf_wr_addr}, 32'd7);
    chk("post_ld_alu_dat", {24'd0, rf_dat_in}, 32'hEE);

    // Store 0x5C -> [0x10], immediate ack; then a stray ack while idle.
    set_op(1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h10, 8'h5C);
    step();
    chk("st_we", {31'd0, mem_we}, 32'd1);
    chk("st_wdata", {24'd0, mem_wdata}, 32'h5C);
    chk("st_addr", {24'd0, mem_addr}, 32'h10);
    chk("st_no_busy", {31'd0, ld_busy}, 32'd0);
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    mem_ack = 1'b1;
    step();
    chk("st_no_wr", {31'd0, rf_wr_en}, 32'd0);
    chk("st_ready", {31'd0, ex_ready}, 32'd1);
    chk("st_req_done", {31'd0, mem_req}, 32'd0);
    step();
    mem_ack = 1'b0;
    chk("idle_ack_no_wr", {31'd0, rf_wr_en}, 32'd0);

    // Load with no ack: abort after TO request cycles.
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 8'h22, 8'h00);
    step();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (TO - 1) step();
    chk("to_last_req", {31'd0, mem_req}, 32'd1);
    chk("to_err_before", {31'd0, err}, 32'd0);
    step();
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_no_wr", {31'd0, rf_wr_en}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h55;
    step();
    mem_ack = 1'b0;
    chk("late_ack_no_wr", {31'd0, rf_wr_en}, 32'd0);
    step();
    chk("err_sticky", {31'd0, err}, 32'd1);
    reset = 1'b1;
    step();
    chk("err_cleared", {31'd0, err}, 32'd0);
    reset = 1'b0;

    // Ack on the last allowed cycle completes the load.
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'd4, 8'h33, 8'h00);
    step();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    repeat (TO - 1) step();
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    step();
    mem_ack = 1'b0;
    chk("edge_ack_en", {31'd0, rf_wr_en}, 32'd1);
    chk("edge_ack_addr", {29'd0, rf_wr_addr}, 32'd4);
    chk("edge_ack_dat", {24'd0, rf_dat_in}, 32'h3C);
    chk("edge_ack_err", {31'd0, err}, 32'd0);

    // Reset during a load's request phase.
    set_op(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 8'h44, 8'h00);
    step();
    set_op(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00);
    step();
    reset = 1'b1;
    step();
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_wr", {31'd0, rf_wr_en}, 32'd0);
    chk("mid_rst_busy", {31'd0, ld_busy}, 32'd0);
    chk("mid_rst_addr", {24'd0, mem_addr}, 32'd0);
    chk("mid_rst_dat", {24'd0, rf_dat_in}, 32'd0);
    reset     = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    step();
    mem_ack = 1'b0;
    chk("mid_rst_late_ack", {31'd0, rf_wr_en}, 32'd0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_unit.md
# wb_unit

Memory-access/writeback stage of the 8-bit core, sitting between the execute stage and the register file write port. Accepts one retired operation per handshake from execute: ALU results go straight to the register file, loads and stores access data memory through a req/ack interface. The unit is the single driver of the register file's data-in, write-enable and write-address inputs, so at most one register write occurs per cycle. Exports the pending load destination for decode-stage hazard stalls.

## Interface
- DW, 8, data width (register file and memory data)
- RAW, 3, register address width (8 registers)
- MAW, 8, data memory address width
- TIMEOUT, 15, max cycles waiting for mem_ack before abort (>=1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute presents an operation
- ex_ready  out  1  unit can accept this cycle
- ex_is_load  in  1  operation is a load
- ex_is_store  in  1  operation is a store (ignored if ex_is_load)
- ex_wr_en  in  1  ALU op writes a register
- ex_wr_addr  in  RAW  destination register
- ex_result  in  DW  ALU result, or memory address for load/store
- ex_store_data  in  DW  store data
- mem_req  out  1  memory request, held until ack or abort
- mem_we  out  1  1=store, 0=load; valid with mem_req
- mem_addr  out  MAW  request address
- mem_wdata  out  DW  store data
- mem_ack  in  1  request done; mem_rdata valid this cycle for loads
- mem_rdata  in  DW  load data
- rf_wr_en  out  1  register file write enable
- rf_wr_addr  out  RAW  register file write address
- rf_dat_in  out  DW  register file write data
- ld_busy  out  1  load in flight
- ld_busy_addr  out  RAW  destination of in-flight load
- err  out  1  sticky: a memory request timed out

## Operation
- States: IDLE, MEM. ex_ready = (state==IDLE) && !reset.
- Accept = ex_valid && ex_ready.
- IDLE, accept ALU op: next cycle rf_wr_en=ex_wr_en, rf_wr_addr/rf_dat_in=ex_wr_addr/ex_result; stay IDLE. Back-to-back ALU ops at 1/cycle.
- IDLE, accept load/store: latch address, data, dest, direction; go MEM; mem_req=1 from next cycle. Load also sets ld_busy/ld_busy_addr.
- MEM: mem_req, mem_we, mem_addr, mem_wdata stable until exit. Wait counter increments each MEM cycle.
- MEM & mem_ack: clear mem_req next cycle, go IDLE. Load: next cycle rf_wr_en=1, rf_wr_addr=latched dest, rf_dat_in=mem_rdata captured at the ack edge. Store: no register write.
- MEM & counter==TIMEOUT-1 & !mem_ack: abort; err<=1, go IDLE, no register write. Ack on the same cycle wins over timeout.
- mem_ack in IDLE: ignored.
- rf_wr_en is a 1-cycle pulse per write; rf_wr_addr/rf_dat_in hold last values when rf_wr_en=0.
- err clears only on reset.

## Timing
- Reset values: state IDLE, ex_ready 0 during reset then 1, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, rf_wr_en 0, rf_wr_addr 0, rf_dat_in 0, ld_busy 0, ld_busy_addr 0, err 0, counter 0.
- ALU latency: accept cycle N -> rf_wr_en at N+1.
- Load with ack at cycle A: mem_req high N+1..A, rf_wr_en at A+1; minimum (ack at N+1) = 2 cycles accept-to-write.
- ld_busy high N+1..A; low at A+1 (the write cycle, consumer uses register file bypass or stalls one more cycle per decode policy).
- ex_ready low N+1..A; next accept at A+1 earliest, its ALU write at A+2, so no write collision.
- Reset mid-MEM: mem_req drops at the reset edge, pending load discarded, no write; a late ack is ignored.
- All outputs registered; no combinational path from mem_ack/mem_rdata to any output except none (ex_ready is state-only).

## Structure
- Shared cpu_pkg: DW/RAW/MAW defaults, wb_state_t enum {IDLE, MEM}, op-kind encoding if decode adopts one.
- One sub-module: wb_timeout (wait counter, clear/enable, expiry flag, width $clog2(TIMEOUT+1)).

## Test plan
- Reset then ALU ops r1=0x12, r2=0x34 in consecutive cycles -> rf_wr_en pulses two consecutive cycles, addr 1/2, data 0x12/0x34.
- Load addr 0x40 into r5, ack after 3 MEM cycles with rdata 0xA7 -> mem_req high 3 cycles, ld_busy_addr=5, ex_ready low, r5<=0xA7 the cycle after ack.
- Store 0x5C to addr 0x10, immediate ack -> mem_we=1, mem_wdata=0x5C, no rf_wr_en, ex_ready high next cycle.
- Load, no ack for TIMEOUT=15 cycles -> abort, err=1, no write; ack arriving later ignored; err holds until reset.
- Ack on the exact timeout cycle -> load completes normally, err stays 0.
- Reset asserted during MEM of a load -> mem_req low next cycle, no rf_wr_en, all outputs at reset values.
